multthree_imp: RTL and testbench
================================

Name: multthree_imp

Overview:
- Clocked controller for a dual-rail, four-phase (return-to-zero) serial divisibility-by-three detector.
- A bit stream arrives MSB first on dual-rail input {in1, in0}. After each bit, the block reports on dual-rail output {parity1, parity0} whether the value accumulated so far is a multiple of three.
- It sits between an asynchronous dual-rail producer and consumer. The inputs are asynchronous to clk and are synchronized internally.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops per input rail (legal values 2..3).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in0  input  1  dual-rail data rail: asserted means the current bit is 0.
- in1  input  1  dual-rail data rail: asserted means the current bit is 1.
- parity0  output  1  asserted means the accumulated value mod 3 is not 0.
- parity1  output  1  asserted means the accumulated value mod 3 is 0.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset state: parity0=0, parity1=0, remainder r=0, FSM in IDLE, synchronizer flops cleared.
- Synchronization: in0 and in1 each pass through SYNC_STAGES flops; the FSM sees only the synchronized values s0 and s1.
- Output registers: parity0 and parity1 are driven directly from flops (glitch-free). They are never asserted together.

FSM states:
- IDLE: outputs low; waiting for a valid codeword.
- ACK: one output high; waiting for the inputs to return to neutral.

IDLE, per clock:
- s0=1, s1=0 → bit b=0; s0=0, s1=1 → bit b=1.
- On a valid bit: r <= (2r + b) mod 3. Assert parity1 if the new r is 0, otherwise assert parity0. Go to ACK.
- Transition table (r,b → r'): (0,0→0), (0,1→1), (1,0→2), (1,1→0), (2,0→1), (2,1→2).
- s0=s1=1 (illegal codeword): no update, outputs stay low, remain in IDLE until both rails return to 0.
- s0=s1=0: remain in IDLE.

ACK:
- Hold the output and r unchanged while either s0 or s1 is 1. A rail change during ACK is ignored.
- When s0=s1=0: drop both outputs on that edge and go to IDLE.

Latency:
- Input rise to output rise: SYNC_STAGES+1 rising edges (3 with the default).
- Input fall to output fall: the same.

Other rules:
- r is a 2-bit register and never takes the value 3. If it does, recover to 0 on the next update.
- r persists across handshakes. Only rst_n clears it, because the stream has no framing.
- Reset asserted mid-handshake clears outputs and r immediately (asynchronously). After reset releases, the FSM restarts in IDLE. If an input is still high at that point, it is treated as a new bit once synchronized.

Optional Feature:
- Macro: MULTTHREE_REM_EN.
- Defined:
  - Adds output port rem [1:0], equal to the current remainder r. It updates on the same edge as parity0/parity1 and resets to 0.
  - Adds output port illegal [0:0], a one-cycle pulse when IDLE sees s0=s1=1.
- Not defined: neither port exists, and the behaviour above is otherwise identical.

Test Plan:
- Reset, then one bit 0 (in0 high until a parity rises, then low) → parity1=1 after 3 clocks, parity0=0; both outputs return to 0 after the inputs return to neutral.
- Stream 1,0,0,1 (value 9) → responses parity0, parity0, parity0, parity1. Check rem=1,2,1,0 with MULTTHREE_REM_EN defined.
- Stream 1,1 (value 3) → parity0, then parity1. A further bit 0 (value 6) → parity1.
- in0 and in1 raised together → no output for at least 10 clocks, r unchanged, illegal pulses once (macro on). Lowering both rails leaves the FSM in IDLE.
- Switch in0 to in1 without returning to neutral during ACK → the output holds its value and r does not change.
- Assert rst_n low while parity0=1 → both outputs go to 0 asynchronously and r=0. Apply bit 0 after release → parity1.

Source files
------------

// File: rtl/multthree_imp.sv
// Dual-rail four-phase serial divisibility-by-three detector: MSB-first bits in, mod-3 verdict out.
// Optional MULTTHREE_REM_EN adds the remainder (rem) and an illegal-codeword pulse (illegal).
module multthree_imp #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in0,
  input  logic       in1,
  output logic       parity0,
  output logic       parity1
`ifdef MULTTHREE_REM_EN
  ,
  output logic [1:0] rem,
  output logic       illegal
`endif
);

  typedef enum logic {
    IDLE,
    ACK
  } state_t;

  logic [SYNC_STAGES-1:0] sync0_reg;
  logic [SYNC_STAGES-1:0] sync1_reg;
  logic                   s0;
  logic                   s1;
  state_t                 state_reg;
  logic [1:0]             r_reg;
  logic [1:0]             r_next;
  logic                   blocked_reg;
`ifdef MULTTHREE_REM_EN
  logic                   illegal_reg;
`endif

  // Each rail gets its own synchronizer chain; the FSM only ever sees the last stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0_reg <= '0;
      sync1_reg <= '0;
    end else begin
      sync0_reg <= {sync0_reg[SYNC_STAGES-2:0], in0};
      sync1_reg <= {sync1_reg[SYNC_STAGES-2:0], in1};
    end
  end

  assign s0 = sync0_reg[SYNC_STAGES-1];
  assign s1 = sync1_reg[SYNC_STAGES-1];

  // (2r + b) mod 3; the unreachable remainder 3 falls back to 0.
  always_comb begin
    r_next = 2'd0;
    case (r_reg)
      2'd0:    r_next = s1 ? 2'd1 : 2'd0;
      2'd1:    r_next = s1 ? 2'd0 : 2'd2;
      2'd2:    r_next = s1 ? 2'd2 : 2'd1;
      default: r_next = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      r_reg       <= 2'd0;
      blocked_reg <= 1'b0;
      parity0     <= 1'b0;
      parity1     <= 1'b0;
`ifdef MULTTHREE_REM_EN
      illegal_reg <= 1'b0;
`endif
    end else begin
`ifdef MULTTHREE_REM_EN
      illegal_reg <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          // After an illegal codeword, nothing counts until both rails are neutral again.
          if (blocked_reg) begin
            if (!s0 && !s1) blocked_reg <= 1'b0;
          end else if (s0 && s1) begin
            blocked_reg <= 1'b1;
`ifdef MULTTHREE_REM_EN
            illegal_reg <= 1'b1;
`endif
          end else if (s0 ^ s1) begin
            r_reg     <= r_next;
            parity1   <= (r_next == 2'd0);
            parity0   <= (r_next != 2'd0);
            state_reg <= ACK;
          end
        end
        ACK: begin
          if (!s0 && !s1) begin
            parity0   <= 1'b0;
            parity1   <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef MULTTHREE_REM_EN
  assign rem     = r_reg;
  assign illegal = illegal_reg;
`endif

endmodule

// File: tb/tb_multthree_imp.sv
// Randomized handshake bench for multthree_imp against a value-mod-3 model.
module tb_multthree_imp;
  localparam int SS  = 2;
  localparam int LAT = SS + 1;

  logic clk = 1'b0;
  logic rst_n;
  logic in0, in1;
  logic parity0, parity1;
`ifdef MULTTHREE_REM_EN
  logic [1:0] rem;
  logic       illegal;
`endif

  int total = 0;
  int bad   = 0;
  int model_r = 0;    // accumulated stream value mod 3
  int mode = 0;       // 0 don't care, 1 both low, 2 hold expected
  int exp_p1 = 0;
  int exp_p0 = 0;
  int illegal_cnt = 0;

  multthree_imp #(.SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .in0(in0), .in1(in1),
    .parity0(parity0), .parity1(parity1)
`ifdef MULTTHREE_REM_EN
    , .rem(rem), .illegal(illegal)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  // Per-cycle comparison against the model, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      chk("exclusive", int'(parity0 & parity1), 0);
      if (mode == 1) begin
        chk("idle_p1", int'(parity1), 0);
        chk("idle_p0", int'(parity0), 0);
      end else if (mode == 2) begin
        chk("hold_p1", int'(parity1), exp_p1);
        chk("hold_p0", int'(parity0), exp_p0);
      end
`ifdef MULTTHREE_REM_EN
      if (mode != 0) chk("rem", int'(rem), model_r);
      if (illegal) illegal_cnt++;
`endif
    end
  end

  task automatic wait_rise(output int n);
    n = 0;
    while (!(parity0 | parity1) && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_fall(output int n);
    n = 0;
    while ((parity0 | parity1) && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  // One full four-phase handshake; sw=1 swaps the rail while the output is held.
  task automatic send_bit(input int b, input int lit, input int sw);
    int n;
    model_r = (2 * model_r + b) % 3;
    exp_p1  = (model_r == 0) ? 1 : 0;
    exp_p0  = 1 - exp_p1;
    mode = 0;
    @(negedge clk);
    if (b != 0) in1 = 1'b1; else in0 = 1'b1;
    wait_rise(n);
    chk("rise_latency", n, LAT);
    chk("p1", int'(parity1), exp_p1);
    chk("p0", int'(parity0), exp_p0);
    if (lit != 2) chk("p1_literal", int'(parity1), lit);
    $display("bit %0d sw=%0d -> parity1=%0d parity0=%0d model_r=%0d", b, sw, parity1, parity0, model_r);
    mode = 2;
    repeat (2) @(negedge clk);
    if (sw != 0) begin
      in0 = ~in0;
      in1 = ~in1;
      repeat (6) @(negedge clk);
    end
    in0 = 1'b0;
    in1 = 1'b0;
    // Output must keep its value for the synchronizer delay after the drop.
    repeat (LAT - 1) @(negedge clk);
    chk("fall_hold", int'(parity0 | parity1), 1);
    mode = 0;
    wait_fall(n);
    chk("fall_latency", n + LAT - 1, LAT);
    mode = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_illegal();
    mode = 1;
    illegal_cnt = 0;
    @(negedge clk);
    in0 = 1'b1;
    in1 = 1'b1;
    repeat (12) @(negedge clk);
    in0 = 1'b0;
    in1 = 1'b0;
    repeat (LAT + 2) @(negedge clk);
`ifdef MULTTHREE_REM_EN
    chk("illegal_pulses", illegal_cnt, 1);
`endif
    $display("illegal codeword -> parity1=%0d parity0=%0d model_r=%0d", parity1, parity0, model_r);
  endtask

  task automatic do_reset();
    mode = 0;
    rst_n = 1'b0;
    in0 = 1'b0;
    in1 = 1'b0;
    model_r = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    mode = 1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    in0 = 1'b0;
    in1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_p1", int'(parity1), 0);
    chk("reset_p0", int'(parity0), 0);
    do_reset();

    send_bit(0, 1, 0);                 // value 0
    do_reset();
    send_bit(1, 0, 0);                 // 1
    send_bit(0, 0, 0);                 // 2
    send_bit(0, 0, 0);                 // 4
    send_bit(1, 1, 0);                 // 9
    do_reset();
    send_bit(1, 0, 0);                 // 1
    send_bit(1, 1, 0);                 // 3
    send_bit(0, 1, 0);                 // 6

    send_illegal();
    send_bit(1, 0, 0);                 // 13 -> r=1, unchanged by the illegal word
    send_bit(0, 0, 1);                 // 26 -> r=2 despite rail swap in ACK
    send_bit(1, 0, 0);                 // 53 -> r=2

    // Asynchronous reset while parity0 is high.
    do_reset();
    model_r = 1;
    mode = 0;
    @(negedge clk);
    in1 = 1'b1;
    wait_rise(n);
    chk("pre_reset_p0", int'(parity0), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_p0", int'(parity0), 0);
    chk("async_p1", int'(parity1), 0);
`ifdef MULTTHREE_REM_EN
    chk("async_rem", int'(rem), 0);
`endif
    in1 = 1'b0;
    model_r = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    mode = 1;
    repeat (3) @(negedge clk);
    send_bit(0, 1, 0);

    for (int i = 0; i < 60; i++) begin
      int act;
      act = $urandom_range(0, 9);
      if (act == 0) send_illegal();
      else send_bit(int'($urandom_range(0, 1)), 2, (act == 1) ? 1 : 0);
    end

    mode = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
